// File: rtl/dmem_arb_pkg.sv
// Shared constants and FSM state encoding for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_AW = 11;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright; on a tie the port
// that was not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = req0 | req1;
  assign gnt_id    = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter in front of a single-port data memory.
// Optional perf counters are built when DMEM_ARB_PERFCNT_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic          w_req0,
  input  logic          w_we0,
  input  logic [AW-1:0] w_addr0,
  input  logic [DW-1:0] w_wdata0,
  output logic          w_ack0,
  input  logic          w_req1,
  input  logic          w_we1,
  input  logic [AW-1:0] w_addr1,
  input  logic [DW-1:0] w_wdata1,
  output logic          w_ack1,
  output logic [DW-1:0] w_rdata,
  output logic [AW-1:0] w_mem_addr,
  output logic          w_mem_we,
  output logic [DW-1:0] w_mem_din,
  input  logic [DW-1:0] w_mem_dout
`ifdef DMEM_ARB_PERFCNT_EN
  ,
  output logic [31:0]   w_cnt_acc0,
  output logic [31:0]   w_cnt_acc1,
  output logic [31:0]   w_cnt_wait
`endif
);

  state_t        state;
  logic          r_win;
  logic          r_we;
  logic          r_last;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  logic          gnt_valid;
  logic          gnt_id;
  logic          other_req;
  logic          load_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req0      (w_req0),
    .req1      (w_req1),
    .last      (r_last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // In RESP the only candidate is the port that was not just served.
  assign other_req = r_win ? w_req0 : w_req1;

  always_comb begin
    load_id   = (state == S_RESP) ? ~r_win : gnt_id;
    sel_we    = load_id ? w_we1    : w_we0;
    sel_addr  = load_id ? w_addr1  : w_addr0;
    sel_wdata = load_id ? w_wdata1 : w_wdata0;
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state   <= S_IDLE;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      w_ack0  <= 1'b0;
      w_ack1  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          w_ack0 <= 1'b0;
          w_ack1 <= 1'b0;
          if (gnt_valid) begin
            r_win   <= load_id;
            r_we    <= sel_we;
            r_addr  <= sel_addr;
            r_wdata <= sel_wdata;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_rdata <= w_mem_dout;
          r_last  <= r_win;
          w_ack0  <= ~r_win;
          w_ack1  <= r_win;
          state   <= S_RESP;
        end
        S_RESP: begin
          w_ack0 <= 1'b0;
          w_ack1 <= 1'b0;
          if (other_req) begin
            r_win   <= load_id;
            r_we    <= sel_we;
            r_addr  <= sel_addr;
            r_wdata <= sel_wdata;
            state   <= S_ACCESS;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          w_ack0 <= 1'b0;
          w_ack1 <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Decoded from state so that an async reset kills a pending write at once.
  assign w_mem_we   = (state == S_ACCESS) & r_we;
  assign w_mem_addr = r_addr;
  assign w_mem_din  = r_wdata;
  assign w_rdata    = r_rdata;

`ifdef DMEM_ARB_PERFCNT_EN
  logic [31:0] cnt_acc0;
  logic [31:0] cnt_acc1;
  logic [31:0] cnt_wait;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      cnt_acc0 <= '0;
      cnt_acc1 <= '0;
      cnt_wait <= '0;
    end else begin
      if (w_ack0)
        cnt_acc0 <= cnt_acc0 + 32'd1;
      if (w_ack1)
        cnt_acc1 <= cnt_acc1 + 32'd1;
      if ((w_req0 | w_req1) & ~(w_ack0 | w_ack1))
        cnt_wait <= cnt_wait + 32'd1;
    end
  end

  assign w_cnt_acc0 = cnt_acc0;
  assign w_cnt_acc1 = cnt_acc1;
  assign w_cnt_wait = cnt_wait;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 2048x32 data memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, ack0;
  logic [10:0] addr0;
  logic [31:0] wdata0;
  logic        req1, we1, ack1;
  logic [10:0] addr1;
  logic [31:0] wdata1;
  logic [31:0] rdata;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
`ifdef DMEM_ARB_PERFCNT_EN
  logic [31:0] cnt_acc0, cnt_acc1, cnt_wait;
`endif

  int checks = 0;
  int errors = 0;
  int bad_we = 0;

  dmem_arbiter dut (
    .w_clk      (clk),
    .w_rst      (rst),
    .w_req0     (req0),
    .w_we0      (we0),
    .w_addr0    (addr0),
    .w_wdata0   (wdata0),
    .w_ack0     (ack0),
    .w_req1     (req1),
    .w_we1      (we1),
    .w_addr1    (addr1),
    .w_wdata1   (wdata1),
    .w_ack1     (ack1),
    .w_rdata    (rdata),
    .w_mem_addr (mem_addr),
    .w_mem_we   (mem_we),
    .w_mem_din  (mem_din),
    .w_mem_dout (mem_dout)
`ifdef DMEM_ARB_PERFCNT_EN
    ,
    .w_cnt_acc0 (cnt_acc0),
    .w_cnt_acc1 (cnt_acc1),
    .w_cnt_wait (cnt_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: sync write, async read; preloaded with A5000000|addr.
  logic [31:0] mem [0:2047];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end
  assign mem_dout = mem[mem_addr];

  // A store strobe must never coincide with an ack (RESP).
  always @(negedge clk) begin
    if (mem_we && (ack0 || ack1)) bad_we <= bad_we + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic wait_ack(input int port, output int lat, output logic [31:0] rd, output int wec);
    lat = 0;
    rd  = '0;
    wec = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_we) wec++;
      if ((port == 0) ? ack0 : ack1) begin
        lat = k;
        rd  = rdata;
        break;
      end
    end
  endtask

  task automatic do_single(input int port, input logic we, input logic [10:0] addr,
                           input logic [31:0] data, output int lat, output logic [31:0] rd,
                           output int wec);
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data;
    end
    wait_ack(port, lat, rd, wec);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  // Both ports raise a load in the same cycle; each drops its req on its ack.
  task automatic tie_pair(output int t0, output int t1, output logic [31:0] rd0,
                          output logic [31:0] rd1);
    t0 = 0; t1 = 0; rd0 = '0; rd1 = '0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'd10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'd20;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ack0) begin t0 = k; rd0 = rdata; req0 = 1'b0; end
      if (ack1) begin t1 = k; rd1 = rdata; req1 = 1'b0; end
      if (t0 != 0 && t1 != 0) break;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          lat, wec, t0, t1, n, tprev, last_t;
    logic [31:0] rd, rd0, rd1;
    logic [3:0]  seq;

    rst = 1'b1; mem_init = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'd3; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // 1: reset held with req0 high
    repeat (3) @(negedge clk);
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {21'd0, mem_addr}, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    mem_init = 1'b0;
    rst = 1'b0;
    wait_ack(0, lat, rd, wec);
    check("first_lat", lat, 2);
    check("first_rd", rd, 32'hA500_0003);
    check("first_load_we", wec, 0);
    req0 = 1'b0;
    @(negedge clk);
    check("ack0_pulse", {31'd0, ack0}, 32'd0);

    // 2: store then load back, plus top-of-memory boundary
    do_single(0, 1'b1, 11'd5, 32'hDEAD_BEEF, lat, rd, wec);
    check("st5_lat", lat, 2);
    check("st5_we_cycles", wec, 1);
    check("st5_mem", mem[5], 32'hDEAD_BEEF);
    do_single(0, 1'b0, 11'd5, 32'h0, lat, rd, wec);
    check("ld5_rd", rd, 32'hDEAD_BEEF);
    check("ld5_we_cycles", wec, 0);
    do_single(1, 1'b1, 11'h7FF, 32'hCAFE_F00D, lat, rd, wec);
    check("st7ff_lat", lat, 2);
    do_single(0, 1'b0, 11'h7FF, 32'h0, lat, rd, wec);
    check("ld7ff_rd", rd, 32'hCAFE_F00D);
    do_single(1, 1'b1, 11'd20, 32'h1111_2222, lat, rd, wec);
    check("st20_we_cycles", wec, 1);

    // 3: simultaneous requests, port1 served last
    tie_pair(t0, t1, rd0, rd1);
    check("tie_t0", t0, 2);
    check("tie_t1", t1, 4);
    check("tie_rd0", rd0, 32'hA500_000A);
    check("tie_rd1", rd1, 32'h1111_2222);

    // 3b: both held, grants alternate
    seq = '0; n = 0; last_t = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'd10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'd20;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        seq = {seq[2:0], ack1};
        n++;
        last_t = k;
        check("alt_rd", rdata, ack1 ? 32'h1111_2222 : 32'hA500_000A);
        if (n == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
          break;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("alt_seq", {28'd0, seq}, 32'h5);
    check("alt_last_t", last_t, 8);

    // 4: lone port1 spaced 3 apart, then port0 cuts in
    n = 0; tprev = 0; t0 = 0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'd20;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ack1 && n < 4) begin
        n++;
        check("lone_gap", k - tprev, (n == 1) ? 2 : 3);
        tprev = k;
        if (n == 4) begin
          req0 = 1'b1; we0 = 1'b0; addr0 = 11'd10;
        end
      end else if (ack0) begin
        t0 = k;
        req0 = 1'b0;
        req1 = 1'b0;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("cutin_t0", t0, 13);

    // 5: reset during the ACCESS cycle of a store
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'd7; wdata0 = 32'h0000_1234;
    @(negedge clk);
    check("abort_we_access", {31'd0, mem_we}, 32'd1);
    check("abort_addr", {21'd0, mem_addr}, 32'd7);
    #2 rst = 1'b1;
    #1;
    check("abort_we_rst", {31'd0, mem_we}, 32'd0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_ack0", {31'd0, ack0}, 32'd0);
    check("abort_mem7", mem[7], 32'hA500_0007);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdata", rdata, 32'd0);
    check("post_rst_ack", {30'd0, ack1, ack0}, 32'd0);
    tie_pair(t0, t1, rd0, rd1);
    check("post_rst_t0", t0, 2);
    check("post_rst_t1", t1, 4);

`ifdef DMEM_ARB_PERFCNT_EN
    // 6: counters over 10 alternating accesses
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("cnt_rst", cnt_acc0 | cnt_acc1 | cnt_wait, 32'd0);
    n = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'd10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'd20;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ack0 || ack1) n++;
      if (n == 10) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    check("cnt_acc0", cnt_acc0, 32'd5);
    check("cnt_acc1", cnt_acc1, 32'd5);
    check("cnt_wait", cnt_wait, 32'd11);
`endif

    check("we_with_ack", bad_we, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
